motor_cmd_sequencer: RTL

//  Sequences the H-bridge motor driver from decoded Bluetooth UART bytes.

---
 rtl/motor_cmd_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/motor_cmd_sequencer.sv
// H-bridge motor command sequencer: turns received UART command bytes into ramped
// PWM duty and direction legs, with dead-time between directions and a command watchdog.
module motor_cmd_sequencer #(
    parameter int unsigned PWM_PRESC    = 1,
    parameter int unsigned RAMP_DIV     = 25000,
    parameter int unsigned RAMP_STEP    = 8,
    parameter int unsigned DEADTIME_CYC = 2500,
    parameter int unsigned WDOG_CYC     = 12500000,
    parameter int unsigned FWD_DUTY     = 130,
    parameter int unsigned REV_DUTY     = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       in1,
    output logic       in2,
    output logic       pwm,
    output logic [7:0] duty,
    output logic [1:0] state,
    output logic       timeout
);
    // state     | meaning
    // IDLE      | legs low, duty 0, waiting for a direction command
    // RUN       | one leg driven, duty ramping toward target
    // RAMP_DOWN | leg still driven, duty ramping to 0 before direction change or stop
    // DEAD      | both legs low for the dead-time, then drive new direction or idle
    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_RUN       = 2'b01,
        S_RAMP_DOWN = 2'b10,
        S_DEAD      = 2'b11
    } state_t;

    typedef enum logic [1:0] {D_NONE, D_FWD, D_REV} dir_t;

    localparam int PW = (PWM_PRESC > 1) ? $clog2(PWM_PRESC) : 1;
    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DW = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;
    localparam int WW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_PRESC - 1);
    localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_DIV - 1);
    localparam logic [DW-1:0] DEAD_LAST  = DW'(DEADTIME_CYC - 1);
    localparam logic [WW-1:0] WDOG_LAST  = WW'(WDOG_CYC - 1);
    localparam logic [7:0]    STEP       = 8'(RAMP_STEP);

    state_t        st;
    dir_t          dir;
    dir_t          pend;
    logic [7:0]    target;
    logic [7:0]    duty_shadow;
    logic [7:0]    pwm_cnt;
    logic [PW-1:0] pdiv;
    logic [RW-1:0] rdiv;
    logic [DW-1:0] dcnt;
    logic [WW-1:0] wdog;
    logic [7:0]    ramp_run;
    logic [7:0]    ramp_dn;
    logic [7:0]    dig_duty;
    logic          tick;
    logic          padv;
    logic          cmd_a;
    logic          cmd_b;
    logic          cmd_s;
    logic          cmd_dig;
    logic          cmd_ok;
    logic          wdog_fire;

    assign state    = st;
    assign tick     = (rdiv == RAMP_LAST);
    assign padv     = (pdiv == PRESC_LAST);
    assign cmd_a    = rx_valid && (rx_data == 8'h41);
    assign cmd_b    = rx_valid && (rx_data == 8'h42);
    assign cmd_s    = rx_valid && (rx_data == 8'h53);
    assign cmd_dig  = rx_valid && (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign cmd_ok   = cmd_a || cmd_b || cmd_s || cmd_dig;
    assign dig_duty = {4'd0, rx_data[3:0]} * 8'd28;
    assign wdog_fire = (st != S_IDLE) && !cmd_ok && (wdog == WDOG_LAST);
    assign pwm      = ((st == S_RUN) || (st == S_RAMP_DOWN)) && (pwm_cnt < duty_shadow);

    // Step toward a target without overshooting it or wrapping past 0/255.
    always_comb begin
        ramp_run = duty;
        if (duty < target)
            ramp_run = ((target - duty) > STEP) ? duty + STEP : target;
        else if (duty > target)
            ramp_run = ((duty - target) > STEP) ? duty - STEP : target;
        ramp_dn = (duty > STEP) ? duty - STEP : 8'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rdiv <= '0;
        else if (tick)
            rdiv <= '0;
        else
            rdiv <= rdiv + 1'b1;
    end

    // Shadow duty only at the PWM period boundary so a period never sees two duties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pdiv        <= '0;
            pwm_cnt     <= '0;
            duty_shadow <= '0;
        end else begin
            pdiv <= padv ? '0 : pdiv + 1'b1;
            if (padv) begin
                pwm_cnt <= pwm_cnt + 1'b1;
                if (pwm_cnt == 8'hFF)
                    duty_shadow <= duty;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st      <= S_IDLE;
            dir     <= D_NONE;
            pend    <= D_NONE;
            target  <= '0;
            duty    <= '0;
            in1     <= 1'b0;
            in2     <= 1'b0;
            dcnt    <= '0;
            wdog    <= '0;
            timeout <= 1'b0;
        end else begin
            if (cmd_a) begin
                pend   <= D_FWD;
                target <= 8'(FWD_DUTY);
            end else if (cmd_b) begin
                pend   <= D_REV;
                target <= 8'(REV_DUTY);
            end else if (cmd_s) begin
                pend <= D_NONE;
            end else if (cmd_dig) begin
                target <= dig_duty;
            end else if (wdog_fire) begin
                pend <= D_NONE;
            end

            if (cmd_ok) begin
                wdog    <= '0;
                timeout <= 1'b0;
            end else if (st == S_IDLE) begin
                wdog <= '0;
            end else if (wdog_fire) begin
                wdog    <= '0;
                timeout <= 1'b1;
            end else begin
                wdog <= wdog + 1'b1;
            end

            // Transitions act on the pend value held before this cycle's byte.
            case (st)
                S_IDLE: begin
                    if (pend != D_NONE) begin
                        st   <= S_DEAD;
                        dcnt <= '0;
                    end
                end
                S_DEAD: begin
                    if (dcnt == DEAD_LAST) begin
                        dcnt <= '0;
                        if (pend == D_NONE) begin
                            st  <= S_IDLE;
                            dir <= D_NONE;
                        end else begin
                            st  <= S_RUN;
                            dir <= pend;
                            in1 <= (pend == D_FWD);
                            in2 <= (pend == D_REV);
                        end
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (pend != dir)
                        st <= S_RAMP_DOWN;
                    else if (tick)
                        duty <= ramp_run;
                end
                S_RAMP_DOWN: begin
                    if (pend == dir) begin
                        st <= S_RUN;
                    end else if ((duty == 8'd0) || (tick && (ramp_dn == 8'd0))) begin
                        st   <= S_DEAD;
                        duty <= '0;
                        in1  <= 1'b0;
                        in2  <= 1'b0;
                        dcnt <= '0;
                    end else if (tick) begin
                        duty <= ramp_dn;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule
